// File: rtl/nrzi_rx.sv
// nrzi_rx -- NRZI line receiver.
//
// Decodes an NRZI line (a 0 bit inverts the level, a 1 bit holds it), hunts
// for the sync byte, strips stuffed zeros and hands completed bytes
// (LSB-first on the line) to a valid/ready output register.
//
// Ports
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   EN     bit strobe; D is consumed only when EN=1
//   D      NRZI line level
//   Q      received byte (holds while QV=0)
//   QV     Q valid
//   QR     consumer ready; transfer on QV&QR
//   SOP    one-cycle pulse after the final sync bit
//   EOP    one-cycle pulse after the frame terminator
//   ERR    one-cycle pulse on a partial-byte EOP or an output overrun
module nrzi_rx #(
  parameter logic [7:0]  SYNC_PAT  = 8'h80,
  parameter int unsigned STUFF_LEN = 6
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       D,
  output logic [7:0] Q,
  output logic       QV,
  input  logic       QR,
  output logic       SOP,
  output logic       EOP,
  output logic       ERR
);

  localparam int OW = $clog2(STUFF_LEN + 1);

  localparam logic [0:0] S_HUNT = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;

  logic [0:0]    state;
  logic          prev;
  logic [7:0]    hist;
  logic [7:0]    sr;
  logic [2:0]    bit_cnt;
  logic [OW-1:0] ones;

  logic       b;
  logic [7:0] hist_nxt;
  logic [7:0] byte_nxt;
  logic       in_data;
  logic       at_lim;
  logic       shift_en;
  logic       byte_done;
  logic       xfer;

  // Same level as the previous strobe decodes as 1.
  assign b         = (D == prev);
  // Both shifters take the new bit at the top so the oldest bit ends in bit 0,
  // which makes the history directly comparable to the LSB-first sync byte.
  assign hist_nxt  = {b, hist[7:1]};
  assign byte_nxt  = {b, sr[7:1]};
  assign in_data   = (state == S_DATA);
  assign at_lim    = (ones == OW'(STUFF_LEN));
  assign shift_en  = EN && in_data && !at_lim;
  assign byte_done = shift_en && (bit_cnt == 3'd7);
  assign xfer      = QV && QR;

  // Line decode, framing and byte assembly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_HUNT;
      prev    <= 1'b1;
      hist    <= 8'h00;
      sr      <= 8'h00;
      bit_cnt <= 3'd0;
      ones    <= '0;
      SOP     <= 1'b0;
      EOP     <= 1'b0;
    end else begin
      SOP <= 1'b0;
      EOP <= 1'b0;
      if (EN) begin
        prev <= D;
        case (state)
          S_HUNT: begin
            hist <= hist_nxt;
            if (hist_nxt == SYNC_PAT) begin
              SOP     <= 1'b1;
              state   <= S_DATA;
              bit_cnt <= 3'd0;
              // The closing 1 of the sync byte already counts toward stuffing.
              ones    <= OW'(1);
            end
          end
          default: begin
            if (at_lim) begin
              if (b) begin
                // A 1 where a stuffed 0 was due terminates the frame.
                EOP   <= 1'b1;
                state <= S_HUNT;
                hist  <= 8'h00;
              end else begin
                ones <= '0;
              end
            end else begin
              sr      <= byte_nxt;
              ones    <= b ? OW'(ones + OW'(1)) : '0;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        endcase
      end
    end
  end

  // Output register and error pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q   <= 8'h00;
      QV  <= 1'b0;
      ERR <= 1'b0;
    end else begin
      ERR <= 1'b0;
      if (EN && in_data && at_lim && b && (bit_cnt != 3'd0))
        ERR <= 1'b1;
      if (byte_done) begin
        // A transfer in the same cycle frees the slot for the new byte.
        if (!QV || QR) begin
          Q  <= byte_nxt;
          QV <= 1'b1;
        end else begin
          ERR <= 1'b1;
        end
      end else if (xfer) begin
        QV <= 1'b0;
      end
    end
  end

endmodule
